// File: rtl/aud_pkg.sv
// Shared audio definitions used by the player and the recorder.
//   aud_state_e : top-level transport state (idle / play / pause)
//   AUD_DATA_W  : sample width in bits
//   AUD_ADDR_W  : SRAM word-address width
package aud_pkg;

    localparam int AUD_DATA_W = 16;
    localparam int AUD_ADDR_W = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE
    } aud_state_e;

endpackage

// File: rtl/aud_player_if.sv
// SRAM read port between the audio player (master) and the SRAM (slave).
//   address   : word address driven by the player
//   sram_data : asynchronous read data for address
interface aud_player_if
    import aud_pkg::*;
#(
    parameter int ADDR_W = AUD_ADDR_W,
    parameter int DATA_W = AUD_DATA_W
);

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] sram_data;

    modport master (output address, input sram_data);
    modport slave  (input address, output sram_data);

endinterface

// File: rtl/aud_dac_serializer.sv
// Parallel-to-serial shifter feeding the codec DAC data line.
//   i_clk    : BCLK
//   i_rst    : synchronous active-high reset
//   i_clr    : synchronous clear (discard the in-flight sample)
//   i_load   : capture i_data and start a DATA_W-bit burst
//   i_data   : sample to serialize, MSB first
//   o_dacdat : registered serial bit; 0 when no burst is in progress
module aud_dac_serializer
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_dacdat
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;

    // The MSB leaves on the edge after the load, so the load cycle itself
    // drives 0 onto the line.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            shift_r  <= '0;
            cnt_r    <= '0;
            o_dacdat <= 1'b0;
        end else if (i_load) begin
            shift_r  <= i_data;
            cnt_r    <= CNT_W'(DATA_W);
            o_dacdat <= 1'b0;
        end else if (cnt_r != '0) begin
            o_dacdat <= shift_r[DATA_W-1];
            shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
            cnt_r    <= cnt_r - CNT_W'(1);
        end else begin
            o_dacdat <= 1'b0;
        end
    end

endmodule

// File: rtl/aud_player.sv
// Audio playback engine: reads samples from SRAM addresses 0..i_end_addr
// and streams them MSB-first onto AUD_DACDAT, one sample per DACLRCK frame.
//   i_clk      : AUD_BCLK
//   i_rst      : synchronous active-high reset
//   i_lrc      : AUD_DACLRCK; a rising edge starts each frame
//   i_start    : level; start from idle or resume from pause
//   i_pause    : rising edge toggles play/pause
//   i_stop     : level; abort to idle
//   i_end_addr : last address to play
//   sram       : SRAM read port (address out, asynchronous data in)
//   o_dacdat   : serial DAC data
//   o_playing  : high while playing
//   o_done     : one-cycle pulse when the last sample's frame ends
module aud_player
    import aud_pkg::*;
#(
    parameter int ADDR_W = AUD_ADDR_W,
    parameter int DATA_W = AUD_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_addr,
    aud_player_if.master      sram,
    output logic              o_dacdat,
    output logic              o_playing,
    output logic              o_done
);

    aud_state_e        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic              last_r;
    logic              lrc_r;
    logic              pause_r;

    logic lrc_rise;
    logic pause_rise;
    logic play_exit;
    logic ser_clr;
    logic ser_load;

    assign sram.address = addr_r;

    always_comb begin
        lrc_rise   = ~lrc_r & i_lrc;
        pause_rise = ~pause_r & i_pause;
        // Any way out of PLAY this cycle: stop, end of last frame, or pause.
        play_exit  = i_stop || (lrc_rise && last_r) || pause_rise;
        ser_clr    = (state_r != S_PLAY) || play_exit;
        ser_load   = (state_r == S_PLAY) && lrc_rise && !play_exit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= S_IDLE;
            addr_r    <= '0;
            last_r    <= 1'b0;
            lrc_r     <= 1'b0;
            pause_r   <= 1'b0;
            o_playing <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            lrc_r   <= i_lrc;
            pause_r <= i_pause;
            o_done  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    addr_r <= '0;
                    last_r <= 1'b0;
                    if (i_start) begin
                        state_r   <= S_PLAY;
                        o_playing <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (i_stop || (lrc_rise && last_r)) begin
                        state_r   <= S_IDLE;
                        addr_r    <= '0;
                        last_r    <= 1'b0;
                        o_playing <= 1'b0;
                        o_done    <= ~i_stop;
                    end else if (pause_rise) begin
                        state_r   <= S_PAUSE;
                        o_playing <= 1'b0;
                    end else if (lrc_rise) begin
                        // The last flag, not wrap-around, ends playback, so
                        // an end address at the top of the range is safe.
                        if (addr_r == i_end_addr) begin
                            last_r <= 1'b1;
                        end else begin
                            addr_r <= addr_r + ADDR_W'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (i_stop) begin
                        state_r <= S_IDLE;
                        addr_r  <= '0;
                        last_r  <= 1'b0;
                    end else if (pause_rise || i_start) begin
                        state_r   <= S_PLAY;
                        o_playing <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    addr_r    <= '0;
                    last_r    <= 1'b0;
                    o_playing <= 1'b0;
                end
            endcase
        end
    end

    aud_dac_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (ser_clr),
        .i_load   (ser_load),
        .i_data   (sram.sram_data),
        .o_dacdat (o_dacdat)
    );

endmodule
